// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: per-stage data/control bundles carried by
// pipe_stage_reg instances, plus small helpers used by the stage register.
// Invariant: every *_control_t encodes NOP as all-zero, so a cleared control
// bundle is always a harmless bubble (no regwrite, no memwrite, no branch).
package cpu_pkg;

  // ALU operation select; ALU_ADD is zero so an all-zero control word is a NOP.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // Memory access size for loads/stores.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  // IF/ID
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_data_t;

  typedef struct packed {
    logic pred_taken;
    logic fetch_fault;
  } if_id_control_t;

  // ID/EX
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
  } id_ex_data_t;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src_imm;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    branch;
    logic    jump;
  } id_ex_control_t;

  // EX/MEM
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
  } ex_mem_data_t;

  typedef struct packed {
    logic      mem_read;
    logic      mem_write;
    logic      reg_write;
    logic      mem_to_reg;
    mem_size_e mem_size;
  } ex_mem_control_t;

  // MEM/WB
  typedef struct packed {
    logic [31:0] wb_value;
    logic [4:0]  rd;
  } mem_wb_data_t;

  typedef struct packed {
    logic reg_write;
  } mem_wb_control_t;

  // Bundle widths, for sizing pipe_stage_reg instances.
  localparam int IF_ID_DATA_W  = $bits(if_id_data_t);
  localparam int IF_ID_CTRL_W  = $bits(if_id_control_t);
  localparam int ID_EX_DATA_W  = $bits(id_ex_data_t);
  localparam int ID_EX_CTRL_W  = $bits(id_ex_control_t);
  localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_control_t);
  localparam int MEM_WB_DATA_W = $bits(mem_wb_data_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_control_t);

  // Slot indices inside a stage register: main feeds the outputs, skid
  // catches the one entry accepted while the main slot is stalled.
  localparam int SLOT_MAIN = 0;
  localparam int SLOT_SKID = 1;

  // Number of held entries from the two slot valid bits.
  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One holding slot of a pipeline stage register: valid flag plus data and
// control bundles. clear only drops the valid flag; payload is left as-is
// so a squash never rewrites the stored bundles.
module pipe_skid_slot
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              valid,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  // Slot state: reset empties and zeroes, clear empties, load captures.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      ctrl_reg  <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= data_in;
      ctrl_reg  <= ctrl_in;
    end
  end

  assign valid    = valid_reg;
  assign data_out = data_reg;
  assign ctrl_out = ctrl_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register between two CPU stages.
// SKID=0: one slot, in_ready is combinational from out_ready.
// SKID=1: main + skid slot, in_ready depends only on registered state, which
// breaks the ready path between stages at the cost of one extra entry.
// flush squashes everything held and anything presented that cycle; a bubble
// always shows an all-zero control bundle (the package NOP encoding).
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [1:0]        occupancy
);

  localparam int NUM_SLOTS = (SKID != 0) ? 2 : 1;

  logic [NUM_SLOTS-1:0] slot_load;
  logic [NUM_SLOTS-1:0] slot_clear;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [DATA_W-1:0]    slot_din  [NUM_SLOTS];
  logic [CTRL_W-1:0]    slot_cin  [NUM_SLOTS];
  logic [DATA_W-1:0]    slot_dout [NUM_SLOTS];
  logic [CTRL_W-1:0]    slot_cout [NUM_SLOTS];

  logic accept;
  logic emit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      pipe_skid_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_slot (
        .clock    (clock),
        .reset    (reset),
        .clear    (slot_clear[gi]),
        .load     (slot_load[gi]),
        .data_in  (slot_din[gi]),
        .ctrl_in  (slot_cin[gi]),
        .valid    (slot_valid[gi]),
        .data_out (slot_dout[gi]),
        .ctrl_out (slot_cout[gi])
      );
    end

    if (SKID == 0) begin : g_single
      // Single register: free to load when empty or draining this cycle.
      always_comb begin
        in_ready   = !reset && (!slot_valid[SLOT_MAIN] || out_ready);
        accept     = in_valid && in_ready;
        emit       = slot_valid[SLOT_MAIN] && out_ready;
        // A flush drops the incoming entry as well as the held one.
        slot_load[SLOT_MAIN]  = accept && !flush;
        slot_clear[SLOT_MAIN] = flush || (emit && !accept);
        slot_din[SLOT_MAIN]   = data_in;
        slot_cin[SLOT_MAIN]   = control_in;
        occupancy             = occ_count(slot_valid[SLOT_MAIN], 1'b0);
      end
    end else begin : g_skid
      logic main_free;

      // Main + skid: the skid entry is always older than any new input, so
      // it has first claim on the main slot when that frees up.
      always_comb begin
        in_ready  = !reset && !slot_valid[SLOT_SKID];
        accept    = in_valid && in_ready;
        emit      = slot_valid[SLOT_MAIN] && out_ready;
        main_free = !slot_valid[SLOT_MAIN] || emit;

        slot_load[SLOT_MAIN]  = !flush && main_free && (slot_valid[SLOT_SKID] || accept);
        slot_clear[SLOT_MAIN] = flush || (main_free && !slot_valid[SLOT_SKID] && !accept);
        slot_din[SLOT_MAIN]   = slot_valid[SLOT_SKID] ? slot_dout[SLOT_SKID] : data_in;
        slot_cin[SLOT_MAIN]   = slot_valid[SLOT_SKID] ? slot_cout[SLOT_SKID] : control_in;

        // Skid only catches an input accepted while main is stalled; in_ready
        // guarantees the skid slot is empty whenever that happens.
        slot_load[SLOT_SKID]  = !flush && !main_free && accept;
        slot_clear[SLOT_SKID] = flush || (main_free && slot_valid[SLOT_SKID]);
        slot_din[SLOT_SKID]   = data_in;
        slot_cin[SLOT_SKID]   = control_in;

        occupancy = occ_count(slot_valid[SLOT_MAIN], slot_valid[SLOT_SKID]);
      end
    end
  endgenerate

  assign out_valid   = slot_valid[SLOT_MAIN];
  assign data_out    = slot_dout[SLOT_MAIN];
  assign control_out = slot_valid[SLOT_MAIN] ? slot_cout[SLOT_MAIN] : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance share the same
// stimulus. Each has a scoreboard queue of accepted-but-not-yet-delivered
// entries; a negedge monitor compares each DUT against its queue and then
// advances the queue from this cycle's inputs.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 8;

  bit            clock;
  logic          reset;
  logic          in_valid;
  logic          flush;
  logic          out_ready;
  logic [DW-1:0] data_in;
  logic [CW-1:0] control_in;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [DW-1:0] data_out0, data_out1;
  logic [CW-1:0] control_out0, control_out1;
  logic [1:0]    occupancy0, occupancy1;

  int checks   = 0;
  int failures = 0;

  logic [DW+CW-1:0] q0[$];
  logic [DW+CW-1:0] q1[$];

  always #5 clock = ~clock;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .data_in(data_in), .control_in(control_in), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .data_out(data_out0),
    .control_out(control_out0), .occupancy(occupancy0)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .data_in(data_in), .control_in(control_in), .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready), .data_out(data_out1),
    .control_out(control_out1), .occupancy(occupancy1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: compare state, then apply this cycle's transfers.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      logic          ov, ir, exp_ir, emit_m;
      logic [DW-1:0] dout;
      logic [CW-1:0] cout;
      logic [1:0]    occ;
      logic [DW+CW-1:0] head;
      int            qs;
      if (d == 0) begin
        ov = out_valid0; ir = in_ready0; dout = data_out0; cout = control_out0;
        occ = occupancy0; qs = q0.size(); head = (qs != 0) ? q0[0] : '0;
      end else begin
        ov = out_valid1; ir = in_ready1; dout = data_out1; cout = control_out1;
        occ = occupancy1; qs = q1.size(); head = (qs != 0) ? q1[0] : '0;
      end

      chk($sformatf("skid%0d_out_valid", d), ov, qs != 0);
      chk($sformatf("skid%0d_occupancy", d), occ, qs);
      if (!ov) chk($sformatf("skid%0d_bubble_ctrl", d), cout, '0);
      else begin
        chk($sformatf("skid%0d_data_out", d), dout, head[DW-1:0]);
        chk($sformatf("skid%0d_control_out", d), cout, head[DW+CW-1:DW]);
      end

      if (reset) exp_ir = 1'b0;
      else if (d == 0) exp_ir = (qs == 0) || out_ready;
      else exp_ir = (qs < 2);
      chk($sformatf("skid%0d_in_ready", d), ir, exp_ir);

      emit_m = (qs != 0) && out_ready;
      if (d == 0) begin
        if (emit_m) void'(q0.pop_front());
        if (reset || flush) q0.delete();
        else if (in_valid && exp_ir) q0.push_back({control_in, data_in});
      end else begin
        if (emit_m) void'(q1.pop_front());
        if (reset || flush) q1.delete();
        else if (in_valid && exp_ir) q1.push_back({control_in, data_in});
      end
    end
  end

  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input logic fl, input logic ordy);
    in_valid = iv; data_in = d; control_in = c; flush = fl; out_ready = ordy;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset held with a valid input presented: nothing may be captured.
    reset = 1'b1; in_valid = 1'b1; data_in = 32'hDEAD_BEEF; control_in = 8'hA5;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Back-to-back streaming with downstream always ready.
    cyc(1'b1, 32'h0000_000A, 8'h11, 1'b0, 1'b1);
    cyc(1'b1, 32'h0000_000B, 8'h12, 1'b0, 1'b1);
    cyc(1'b1, 32'h0000_000C, 8'h13, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);

    // Stall with two entries sent: skid instance must fill and hold A.
    cyc(1'b1, 32'h1111_AAAA, 8'h21, 1'b0, 1'b0);
    cyc(1'b1, 32'h2222_BBBB, 8'h22, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    chk("stall_in_ready", in_ready1, 1'b0);
    chk("stall_occupancy", occupancy1, 2'd2);
    chk("stall_data_out", data_out1, 32'h1111_AAAA);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("stall_hold_data", data_out1, 32'h1111_AAAA);
    chk("stall_hold_ctrl", control_out1, 8'h21);
    @(posedge clock);
    #1;
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);

    // Flush with a full skid stage and an input presented in the flush cycle.
    cyc(1'b1, 32'h3333_DDDD, 8'h31, 1'b0, 1'b0);
    cyc(1'b1, 32'h4444_EEEE, 8'h32, 1'b0, 1'b0);
    cyc(1'b1, 32'h5555_CCCC, 8'h33, 1'b1, 1'b0);
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    chk("flush_out_valid", out_valid1, 1'b0);
    chk("flush_occupancy", occupancy1, 2'd0);
    chk("flush_control_out", control_out1, 8'h00);
    @(posedge clock);
    #1;

    // SKID=0 handover: stalled entry, then ready and new input together.
    cyc(1'b1, 32'h6666_0001, 8'h41, 1'b0, 1'b0);
    in_valid = 1'b1; data_in = 32'h7777_0002; control_in = 8'h42; out_ready = 1'b0;
    @(negedge clock);
    chk("handover_stall_in_ready", in_ready0, 1'b0);
    @(posedge clock);
    #1;
    cyc(1'b1, 32'h7777_0002, 8'h42, 1'b0, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    chk("handover_out_valid", out_valid0, 1'b1);
    chk("handover_data_out", data_out0, 32'h7777_0002);
    @(posedge clock);
    #1;

    // Randomized valid/ready/flush with occasional reset.
    for (int i = 0; i < 10000; i++) begin
      reset = ($urandom_range(0, 999) < 2);
      cyc($urandom_range(0, 9) < 7, $urandom, 8'($urandom),
          $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6);
    end
    reset = 1'b0;

    // Drain: both stages must end empty.
    repeat (4) cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
    @(negedge clock);
    chk("drain_out_valid0", out_valid0, 1'b0);
    chk("drain_out_valid1", out_valid1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
